// File: rtl/hazard_ctrl.sv
// Pipeline hazard sequencer: load-use stall and branch-flush controls,
// execute-stage forwarding selects and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int FLUSH_CYCLES      = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       i_d_rs1,
    input  logic [4:0]       i_d_rs2,
    input  logic             i_d_use_rs1,
    input  logic             i_d_use_rs2,
    input  logic [4:0]       i_e_rs1,
    input  logic [4:0]       i_e_rs2,
    input  logic [4:0]       i_e_rd,
    input  logic             i_e_reg_wr_en,
    input  logic             i_e_is_load,
    input  logic [4:0]       i_m_rd,
    input  logic             i_m_reg_wr_en,
    input  logic             i_m_is_load,
    input  logic [4:0]       i_w_rd,
    input  logic             i_w_reg_wr_en,
    input  logic             i_br_taken,
    output logic             o_stall_f,
    output logic             o_bubble_de,
    output logic             o_flush_fd,
    output logic             o_flush_em,
    output logic [1:0]       o_fwd_a,
    output logic [1:0]       o_fwd_b,
    output logic [CNT_W-1:0] o_stall_cnt,
    output logic [CNT_W-1:0] o_flush_cnt
);

    typedef enum logic [1:0] {RUN, LD_STALL, BR_FLUSH} state_t;

    localparam logic [2:0] LD_RELOAD = 3'(LOAD_STALL_CYCLES - 1);
    localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t     state;
    logic [2:0] cnt;
    logic       ld_hz;
    logic       stall_inc;
    logic       flush_inc;

    assign ld_hz = i_e_is_load & i_e_reg_wr_en & (i_e_rd != 5'd0) &
                   ((i_d_use_rs1 & (i_d_rs1 == i_e_rd)) |
                    (i_d_use_rs2 & (i_d_rs2 == i_e_rd)));

    // A load in M is never a forwarding source; the stall routes its data through W.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src);
        if (i_m_reg_wr_en && !i_m_is_load && i_m_rd != 5'd0 && i_m_rd == src)
            return 2'b01;
        else if (i_w_reg_wr_en && i_w_rd != 5'd0 && i_w_rd == src)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    always_comb begin
        o_stall_f   = 1'b0;
        o_bubble_de = 1'b0;
        o_flush_fd  = 1'b0;
        o_flush_em  = 1'b0;
        o_fwd_a     = 2'b00;
        o_fwd_b     = 2'b00;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!reset) begin
            o_fwd_a = fwd_sel(i_e_rs1);
            o_fwd_b = fwd_sel(i_e_rs2);
            if (i_br_taken) begin
                o_flush_fd  = 1'b1;
                o_bubble_de = 1'b1;
                o_flush_em  = 1'b1;
                flush_inc   = 1'b1;
            end else begin
                case (state)
                    RUN: if (ld_hz) begin
                        o_stall_f   = 1'b1;
                        o_bubble_de = 1'b1;
                        stall_inc   = 1'b1;
                    end
                    LD_STALL: begin
                        o_stall_f   = 1'b1;
                        o_bubble_de = 1'b1;
                        stall_inc   = 1'b1;
                    end
                    BR_FLUSH: begin
                        o_flush_fd  = 1'b1;
                        o_bubble_de = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            cnt         <= 3'd0;
            o_stall_cnt <= '0;
            o_flush_cnt <= '0;
        end else begin
            if (i_br_taken) begin
                cnt   <= FL_RELOAD;
                state <= (FLUSH_CYCLES > 1) ? BR_FLUSH : RUN;
            end else begin
                case (state)
                    RUN: if (ld_hz) begin
                        cnt   <= LD_RELOAD;
                        state <= (LOAD_STALL_CYCLES > 1) ? LD_STALL : RUN;
                    end
                    LD_STALL, BR_FLUSH: begin
                        cnt <= cnt - 3'd1;
                        if (cnt <= 3'd1)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end
            if (stall_inc && o_stall_cnt != '1)
                o_stall_cnt <= o_stall_cnt + CNT_W'(1);
            if (flush_inc && o_flush_cnt != '1)
                o_flush_cnt <= o_flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: three parameterisations share one stimulus stream;
// expectations go through a scoreboard queue and are checked on the falling edge.
module tb_hazard_ctrl;

    typedef struct packed {
        logic [4:0] d_rs1, d_rs2;
        logic       d_use1, d_use2;
        logic [4:0] e_rs1, e_rs2, e_rd;
        logic       e_wr, e_ld;
        logic [4:0] m_rd;
        logic       m_wr, m_ld;
        logic [4:0] w_rd;
        logic       w_wr, br;
    } in_t;

    typedef struct packed {
        in_t        i;
        logic [7:0] ctl;   // {stall, bubble, flush_fd, flush_em, fwd_a, fwd_b}
    } vec_t;

    typedef struct {
        string       name;
        int          dut;
        logic [7:0]  ctl;
        bit          chk;
        logic [31:0] sc, fc;
    } exp_t;

    localparam logic [7:0] NONE  = 8'b0000_0000;
    localparam logic [7:0] STALL = 8'b1100_0000;
    localparam logic [7:0] BRALL = 8'b0111_0000;
    localparam logic [7:0] BRFL  = 8'b0110_0000;

    logic clk = 1'b0, reset = 1'b1;
    logic [4:0] d_rs1, d_rs2, e_rs1, e_rs2, e_rd, m_rd, w_rd;
    logic d_use1, d_use2, e_wr, e_ld, m_wr, m_ld, w_wr, br;

    logic       st[3], bu[3], ffd[3], fem[3];
    logic [1:0] fa[3], fb[3];
    logic [31:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;
    logic [7:0]  sc_c, fc_c;

    int n_cmp = 0, n_err = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(1), .CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_use_rs1(d_use1), .i_d_use_rs2(d_use2), .i_e_rs1(e_rs1), .i_e_rs2(e_rs2),
        .i_e_rd(e_rd), .i_e_reg_wr_en(e_wr), .i_e_is_load(e_ld), .i_m_rd(m_rd),
        .i_m_reg_wr_en(m_wr), .i_m_is_load(m_ld), .i_w_rd(w_rd), .i_w_reg_wr_en(w_wr),
        .i_br_taken(br), .o_stall_f(st[0]), .o_bubble_de(bu[0]), .o_flush_fd(ffd[0]),
        .o_flush_em(fem[0]), .o_fwd_a(fa[0]), .o_fwd_b(fb[0]),
        .o_stall_cnt(sc_a), .o_flush_cnt(fc_a));

    hazard_ctrl #(.LOAD_STALL_CYCLES(3), .FLUSH_CYCLES(1), .CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_use_rs1(d_use1), .i_d_use_rs2(d_use2), .i_e_rs1(e_rs1), .i_e_rs2(e_rs2),
        .i_e_rd(e_rd), .i_e_reg_wr_en(e_wr), .i_e_is_load(e_ld), .i_m_rd(m_rd),
        .i_m_reg_wr_en(m_wr), .i_m_is_load(m_ld), .i_w_rd(w_rd), .i_w_reg_wr_en(w_wr),
        .i_br_taken(br), .o_stall_f(st[1]), .o_bubble_de(bu[1]), .o_flush_fd(ffd[1]),
        .o_flush_em(fem[1]), .o_fwd_a(fa[1]), .o_fwd_b(fb[1]),
        .o_stall_cnt(sc_b), .o_flush_cnt(fc_b));

    hazard_ctrl #(.LOAD_STALL_CYCLES(1), .FLUSH_CYCLES(3), .CNT_W(8)) dut_c (
        .clk(clk), .reset(reset), .i_d_rs1(d_rs1), .i_d_rs2(d_rs2),
        .i_d_use_rs1(d_use1), .i_d_use_rs2(d_use2), .i_e_rs1(e_rs1), .i_e_rs2(e_rs2),
        .i_e_rd(e_rd), .i_e_reg_wr_en(e_wr), .i_e_is_load(e_ld), .i_m_rd(m_rd),
        .i_m_reg_wr_en(m_wr), .i_m_is_load(m_ld), .i_w_rd(w_rd), .i_w_reg_wr_en(w_wr),
        .i_br_taken(br), .o_stall_f(st[2]), .o_bubble_de(bu[2]), .o_flush_fd(ffd[2]),
        .o_flush_em(fem[2]), .o_fwd_a(fa[2]), .o_fwd_b(fb[2]),
        .o_stall_cnt(sc_c), .o_flush_cnt(fc_c));

    task automatic apply(input in_t x);
        d_rs1 = x.d_rs1; d_rs2 = x.d_rs2; d_use1 = x.d_use1; d_use2 = x.d_use2;
        e_rs1 = x.e_rs1; e_rs2 = x.e_rs2; e_rd = x.e_rd; e_wr = x.e_wr; e_ld = x.e_ld;
        m_rd = x.m_rd; m_wr = x.m_wr; m_ld = x.m_ld;
        w_rd = x.w_rd; w_wr = x.w_wr; br = x.br;
    endtask

    task automatic ex(input string name, input int d, input logic [7:0] ctl,
                      input bit chk, input int sc, input int fc);
        exp_t e;
        e.name = name; e.dut = d; e.ctl = ctl; e.chk = chk;
        e.sc = 32'(sc); e.fc = 32'(fc);
        sb.push_back(e);
    endtask

    // Sample on the falling edge, drain the scoreboard, then step past the next rising edge.
    task automatic tick();
        exp_t e;
        logic [7:0]  act;
        logic [31:0] asc, afc;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            act = {st[e.dut], bu[e.dut], ffd[e.dut], fem[e.dut], fa[e.dut], fb[e.dut]};
            case (e.dut)
                0:       begin asc = sc_a;       afc = fc_a;       end
                1:       begin asc = 32'(sc_b);  afc = 32'(fc_b);  end
                default: begin asc = 32'(sc_c);  afc = 32'(fc_c);  end
            endcase
            n_cmp++;
            if (act !== e.ctl || (e.chk && (asc !== e.sc || afc !== e.fc))) begin
                n_err++;
                $display("FAIL %s dut%0d: got ctl=%b sc=%0d fc=%0d, want ctl=%b sc=%0d fc=%0d",
                         e.name, e.dut, act, asc, afc, e.ctl, e.sc, e.fc);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_t z;
        z = '0;
        apply(z);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    in_t hz, z, x;
    vec_t v;

    initial begin
        z = '0;
        hz = '0; hz.e_ld = 1; hz.e_wr = 1; hz.e_rd = 5'd5; hz.d_rs1 = 5'd5; hz.d_use1 = 1;

        // Reset with hostile inputs: everything must stay quiet.
        x = hz; x.br = 1; x.e_rs1 = 5'd3; x.m_rd = 5'd3; x.m_wr = 1;
        apply(x);
        reset = 1'b1;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) ex("reset", d, NONE, 1, 0, 0);
        tick();
        reset = 1'b0;

        // Combinational table on dut_a (L=1, F=1 keeps it in RUN).
        v = '0; tbl.push_back(v);
        v = '0; v.i = hz; v.ctl = STALL; tbl.push_back(v);
        v = '0; v.i = hz; v.i.d_use1 = 0; tbl.push_back(v);
        v = '0; v.i.e_ld = 1; v.i.e_wr = 1; v.i.e_rd = 7; v.i.d_rs2 = 7; v.i.d_use2 = 1; v.ctl = STALL; tbl.push_back(v);
        v = '0; v.i.e_ld = 1; v.i.e_wr = 1; v.i.d_use1 = 1; tbl.push_back(v);
        v = '0; v.i = hz; v.i.e_ld = 0; tbl.push_back(v);
        v = '0; v.i = hz; v.i.e_wr = 0; tbl.push_back(v);
        v = '0; v.i = hz; v.i.br = 1; v.ctl = BRALL; tbl.push_back(v);
        v = '0; v.i.m_rd = 3; v.i.m_wr = 1; v.i.w_rd = 3; v.i.w_wr = 1; v.i.e_rs1 = 3; v.ctl = 8'b0000_0100; tbl.push_back(v);
        v = '0; v.i.m_wr = 1; v.i.w_rd = 3; v.i.w_wr = 1; v.i.e_rs1 = 3; v.ctl = 8'b0000_1000; tbl.push_back(v);
        v = '0; v.i.m_rd = 3; v.i.m_wr = 1; v.i.m_ld = 1; v.i.w_rd = 3; v.i.w_wr = 1; v.i.e_rs1 = 3; v.ctl = 8'b0000_1000; tbl.push_back(v);
        v = '0; v.i.m_rd = 3; v.i.m_wr = 1; v.i.m_ld = 1; v.i.e_rs1 = 3; tbl.push_back(v);
        v = '0; v.i.e_rs1 = 4; v.i.e_rs2 = 9; v.i.m_rd = 9; v.i.m_wr = 1; v.i.w_rd = 4; v.i.w_wr = 1; v.ctl = 8'b0000_1001; tbl.push_back(v);
        v = '0; v.i.m_wr = 1; v.i.w_wr = 1; tbl.push_back(v);
        v = '0; v.i.e_rs1 = 6; v.i.e_rs2 = 6; v.i.m_rd = 6; v.i.w_rd = 6; v.i.w_wr = 1; v.ctl = 8'b0000_1010; tbl.push_back(v);
        foreach (tbl[k]) begin
            apply(tbl[k].i);
            ex($sformatf("tbl%0d", k), 0, tbl[k].ctl, 0, 0, 0);
            tick();
        end

        // Load-use, single bubble, then MW forward of the loaded value.
        do_reset();
        apply(hz); ex("lu_stall", 0, STALL, 1, 0, 0); tick();
        x = z; x.d_rs1 = 5; x.d_use1 = 1; x.m_rd = 5; x.m_wr = 1; x.m_ld = 1;
        apply(x); ex("lu_bubble", 0, NONE, 1, 1, 0); tick();
        x = z; x.e_rs1 = 5; x.w_rd = 5; x.w_wr = 1;
        apply(x); ex("lu_fwd", 0, 8'b0000_1000, 1, 1, 0); tick();

        // Three-cycle stall.
        do_reset();
        apply(hz); ex("ls3_c1", 1, STALL, 1, 0, 0); tick();
        x = z; x.d_rs1 = 5; x.d_use1 = 1;
        apply(x); ex("ls3_c2", 1, STALL, 1, 1, 0); tick();
        ex("ls3_c3", 1, STALL, 1, 2, 0); tick();
        ex("ls3_run", 1, NONE, 1, 3, 0); tick();

        // Branch flush: one-cycle (dut_a) and three-cycle with restart (dut_c).
        do_reset();
        x = z; x.br = 1;
        apply(x); ex("br_a1", 0, BRALL, 1, 0, 0); ex("br_c1", 2, BRALL, 1, 0, 0); tick();
        apply(z); ex("br_a2", 0, NONE, 1, 0, 1); ex("br_c2", 2, BRFL, 1, 0, 1); tick();
        apply(x); ex("br_a3", 0, BRALL, 1, 0, 1); ex("br_c3", 2, BRALL, 1, 0, 1); tick();
        apply(z); ex("br_c4", 2, BRFL, 1, 0, 2); tick();
        ex("br_c5", 2, BRFL, 1, 0, 2); tick();
        ex("br_c6", 2, NONE, 1, 0, 2); ex("br_a6", 0, NONE, 1, 0, 2); tick();

        // Branch aborting a load stall.
        do_reset();
        apply(hz); ex("ab_c1", 1, STALL, 1, 0, 0); tick();
        x = z; x.br = 1;
        apply(x); ex("ab_c2", 1, BRALL, 1, 1, 0); tick();
        apply(z); ex("ab_c3", 1, NONE, 1, 1, 1); tick();

        // Stall counter saturation, then reset mid-stall.
        do_reset();
        apply(hz);
        for (int k = 0; k < 18; k++) tick();
        ex("sat1", 1, STALL, 1, 15, 0); tick();
        ex("sat2", 1, STALL, 1, 15, 0); tick();
        reset = 1'b1;
        ex("rst_mid", 1, NONE, 1, 15, 0); tick();
        ex("rst_clr", 1, NONE, 1, 0, 0); tick();
        reset = 1'b0;
        apply(z);
        ex("rst_run", 1, NONE, 1, 0, 0); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
